// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_defs : shared definitions for the game-RAM arbiter.
//   - FSM state encoding (S_IDLE / S_ACCESS / S_WAIT)
//   - requester IDs (REQ_P1=0, REQ_P2=1, REQ_VGA=2)
//   - default RAM geometry, shared with the ram32x20 instantiations
// ---------------------------------------------------------------------------
package mem_arbiter_defs;

   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_DATA_W = 20;
   localparam int unsigned NUM_REQ    = 3;
   localparam int unsigned CNT_W      = 2;   // holds READ_LAT up to 3

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REQ_P1  = 2'd0,
      REQ_P2  = 2'd1,
      REQ_VGA = 2'd2
   } req_id_t;

   // Requester that follows id in the round-robin ring p1 -> p2 -> vga -> p1.
   function automatic req_id_t next_id(input req_id_t id);
      unique case (id)
         REQ_P1:  return REQ_P2;
         REQ_P2:  return REQ_VGA;
         default: return REQ_P1;
      endcase
   endfunction

   // One-hot grant vector to requester ID.
   function automatic req_id_t onehot3_to_id(input logic [NUM_REQ-1:0] g);
      if (g[1])      return REQ_P2;
      else if (g[2]) return REQ_VGA;
      else           return REQ_P1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3 : combinational 3-way round-robin selector.
//   req   in  3  request vector, bit index = requester ID
//   ptr   in  2  requester searched first; search wraps ptr, ptr+1, ptr+2
//   grant out 3  one-hot winner (all zero when no request)
//   any   out 1  at least one request present
// ---------------------------------------------------------------------------
module rr_pick3
   import mem_arbiter_defs::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               any
);

   always_comb begin
      grant = '0;
      unique case (ptr)
         2'd1: begin
            if      (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
         end
         2'd2: begin
            if      (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
         end
         // ptr 0, and the unused code 3, start at p1
         default: begin
            if      (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
         end
      endcase
   end

   assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : shares the single-port 32x20 game RAM between player1
// (writer), player2 (reader) and the VGA renderer (reader).
//   clock, resetn             clock, async active-low reset
//   p1_req/p1_addr/p1_wdata   player1 write request;  p1_gnt grant pulse
//   p2_req/p2_addr            player2 read request;   p2_gnt, p2_rvalid pulses
//   vga_req/vga_addr          VGA read request;       vga_gnt, vga_rvalid pulses
//   rdata                     read data, qualified by p2_rvalid / vga_rvalid
//   ram_address/ram_data/ram_wren/ram_q   RAM pins
//   busy                      high whenever the access FSM is not idle
// A request seen in IDLE in cycle N is granted in N+1 (ACCESS); a read
// returns rdata with rvalid in N+2+READ_LAT, coinciding with IDLE.
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_defs::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned READ_LAT = 1
)(
   input  logic              clock,
   input  logic              resetn,
   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   input  logic              p2_req,
   input  logic [ADDR_W-1:0] p2_addr,
   output logic              p2_gnt,
   output logic              p2_rvalid,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
);

   state_t              r_state;
   req_id_t             r_ptr;
   req_id_t             r_owner;
   logic [CNT_W-1:0]    r_cnt;

   state_t              w_state_nxt;
   req_id_t             w_ptr_nxt;
   req_id_t             w_owner_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [DATA_W-1:0]   w_data_nxt;
   logic                w_wren_nxt;
   logic [NUM_REQ-1:0]  w_gnt_nxt;
   logic                w_p2_rv_nxt;
   logic                w_vga_rv_nxt;
   logic [DATA_W-1:0]   w_rdata_nxt;

   logic [NUM_REQ-1:0]  w_grant;
   logic                w_any;
   req_id_t             w_win_id;

   rr_pick3 u_pick (
      .req   ({vga_req, p2_req, p1_req}),
      .ptr   (r_ptr),
      .grant (w_grant),
      .any   (w_any)
   );

   assign w_win_id = onehot3_to_id(w_grant);

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_owner_nxt  = r_owner;
      w_cnt_nxt    = r_cnt;
      w_addr_nxt   = ram_address;
      w_data_nxt   = ram_data;
      w_wren_nxt   = 1'b0;
      w_gnt_nxt    = '0;
      w_p2_rv_nxt  = 1'b0;
      w_vga_rv_nxt = 1'b0;
      w_rdata_nxt  = rdata;

      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_ACCESS;
               w_owner_nxt = w_win_id;
               w_ptr_nxt   = next_id(w_win_id);
               w_gnt_nxt   = w_grant;
               unique case (w_win_id)
                  REQ_P1: begin
                     w_addr_nxt = p1_addr;
                     w_data_nxt = p1_wdata;
                     w_wren_nxt = 1'b1;
                  end
                  REQ_P2:  w_addr_nxt = p2_addr;
                  default: w_addr_nxt = vga_addr;
               endcase
            end
         end

         S_ACCESS: begin
            if (r_owner == REQ_P1) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = CNT_W'(READ_LAT);
            end
         end

         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            // Last wait cycle: q is valid now, strobe rvalid next cycle.
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt  = S_IDLE;
               w_rdata_nxt  = ram_q;
               w_p2_rv_nxt  = (r_owner == REQ_P2);
               w_vga_rv_nxt = (r_owner == REQ_VGA);
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_ptr       <= REQ_P1;
         r_owner     <= REQ_P1;
         r_cnt       <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
         p1_gnt      <= 1'b0;
         p2_gnt      <= 1'b0;
         vga_gnt     <= 1'b0;
         p2_rvalid   <= 1'b0;
         vga_rvalid  <= 1'b0;
         rdata       <= '0;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_owner     <= w_owner_nxt;
         r_cnt       <= w_cnt_nxt;
         ram_address <= w_addr_nxt;
         ram_data    <= w_data_nxt;
         ram_wren    <= w_wren_nxt;
         p1_gnt      <= w_gnt_nxt[REQ_P1];
         p2_gnt      <= w_gnt_nxt[REQ_P2];
         vga_gnt     <= w_gnt_nxt[REQ_VGA];
         p2_rvalid   <= w_p2_rv_nxt;
         vga_rvalid  <= w_vga_rv_nxt;
         rdata       <= w_rdata_nxt;
         busy        <= (w_state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : self-checking bench for mem_arbiter (READ_LAT = 2).
// The reference model is a transaction scheduler: when the arbiter is free
// and someone requests, it picks the round-robin winner and schedules the
// grant, write commit, rvalid and the next free cycle by plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int unsigned AW = mem_arbiter_defs::DEF_ADDR_W;
   localparam int unsigned DW = mem_arbiter_defs::DEF_DATA_W;
   localparam int unsigned RL = 2;

   logic          clock = 1'b0;
   logic          resetn;
   logic          p1_req, p2_req, vga_req;
   logic [AW-1:0] p1_addr, p2_addr, vga_addr;
   logic [DW-1:0] p1_wdata;
   logic          p1_gnt, p2_gnt, vga_gnt, p2_rvalid, vga_rvalid;
   logic [DW-1:0] rdata;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [DW-1:0] ram_q;
   logic          busy;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .p1_req      (p1_req),
      .p1_addr     (p1_addr),
      .p1_wdata    (p1_wdata),
      .p1_gnt      (p1_gnt),
      .p2_req      (p2_req),
      .p2_addr     (p2_addr),
      .p2_gnt      (p2_gnt),
      .p2_rvalid   (p2_rvalid),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_gnt     (vga_gnt),
      .vga_rvalid  (vga_rvalid),
      .rdata       (rdata),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .busy        (busy)
   );

   // RAM environment: address registered at the RAM, q valid RL cycles later.
   logic [DW-1:0] ram [0:31];
   logic [AW-1:0] ram_areg;
   logic [DW-1:0] q_d1, q_d2;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;

   always @(posedge clock) begin
      if (load_en)       ram[load_addr]   <= load_data;
      else if (ram_wren) ram[ram_address] <= ram_data;
      ram_areg <= ram_address;
      q_d1     <= ram[ram_areg];
      q_d2     <= q_d1;
   end

   assign ram_q = (RL == 1) ? ram[ram_areg] : (RL == 2) ? q_d1 : q_d2;

   // Checking
   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
   endtask

   // Reference model
   logic [DW-1:0] mem_m [0:31];
   int            free_at, busy_from, gnt_cyc, gnt_who, rv_cyc, rv_who, ptr_m;
   logic [AW-1:0] gnt_addr;
   logic [DW-1:0] gnt_wdata, rv_data, exp_rdata;
   bit            hold_all;

   task automatic model_reset();
      cyc = 0; free_at = 0; busy_from = 0; gnt_cyc = -1; gnt_who = 0;
      rv_cyc = -1; rv_who = 0; ptr_m = 0; exp_rdata = '0;
   endtask

   task automatic drop_req(input int who);
      case (who)
         0:       p1_req  = 1'b0;
         1:       p2_req  = 1'b0;
         default: vga_req = 1'b0;
      endcase
   endtask

   // One clock cycle: compare at negedge, arbitrate in the model, advance.
   task automatic step();
      logic [2:0] g, rq;
      logic [6:0] exp_ctl, got_ctl;
      logic       e_wren, e_rv2, e_rvv, e_busy;
      int         w;
      @(negedge clock);
      g      = (cyc == gnt_cyc) ? 3'(3'b001 << gnt_who) : 3'b000;
      e_wren = (cyc == gnt_cyc) && (gnt_who == 0);
      e_rv2  = (cyc == rv_cyc) && (rv_who == 1);
      e_rvv  = (cyc == rv_cyc) && (rv_who == 2);
      e_busy = (cyc >= busy_from) && (cyc < free_at);
      if (cyc == rv_cyc) exp_rdata = rv_data;
      exp_ctl = {g[0], g[1], g[2], e_rv2, e_rvv, e_wren, e_busy};
      got_ctl = {p1_gnt, p2_gnt, vga_gnt, p2_rvalid, vga_rvalid, ram_wren, busy};
      check("ctl{g1,g2,gv,rv2,rvv,wren,busy}", 32'(got_ctl), 32'(exp_ctl));
      check("rdata", 32'(rdata), 32'(exp_rdata));
      if (cyc == gnt_cyc) begin
         check("ram_address", 32'(ram_address), 32'(gnt_addr));
         if (gnt_who == 0) check("ram_data", 32'(ram_data), 32'(gnt_wdata));
      end

      rq = {vga_req, p2_req, p1_req};
      if (cyc >= free_at && rq != 3'b000) begin
         w = -1;
         for (int k = 0; k < 3; k++)
            if (w < 0 && rq[(ptr_m + k) % 3]) w = (ptr_m + k) % 3;
         ptr_m     = (w + 1) % 3;
         gnt_cyc   = cyc + 1;
         gnt_who   = w;
         busy_from = cyc + 1;
         case (w)
            0: begin
               gnt_addr  = p1_addr;
               gnt_wdata = p1_wdata;
               mem_m[p1_addr] = p1_wdata;
               free_at   = cyc + 2;
            end
            default: begin
               gnt_addr = (w == 1) ? p2_addr : vga_addr;
               rv_cyc   = cyc + 2 + RL;
               rv_who   = w;
               rv_data  = mem_m[gnt_addr];
               free_at  = cyc + 2 + RL;
            end
         endcase
      end

      @(posedge clock); #1;
      cyc++;
      if (!hold_all && gnt_cyc == cyc - 1) drop_req(gnt_who);
   endtask

   // Idle requesters randomly raise a new request (never in the cycle right after their grant).
   task automatic rand_reqs();
      bit just = (gnt_cyc == cyc - 1);
      if (!p1_req && !(just && gnt_who == 0) && $urandom_range(0, 3) == 0) begin
         p1_req = 1'b1; p1_addr = AW'($urandom); p1_wdata = DW'($urandom);
      end
      if (!p2_req && !(just && gnt_who == 1) && $urandom_range(0, 3) == 0) begin
         p2_req = 1'b1; p2_addr = AW'($urandom);
      end
      if (!vga_req && !(just && gnt_who == 2) && $urandom_range(0, 3) == 0) begin
         vga_req = 1'b1; vga_addr = AW'($urandom);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_ctl"}, 32'({p1_gnt, p2_gnt, vga_gnt, p2_rvalid, vga_rvalid, ram_wren, busy}), 32'd0);
      check({tag, "_rdata"}, 32'(rdata), 32'd0);
      check({tag, "_addr"}, 32'(ram_address), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clock); resetn = 1'b1;
      @(posedge clock); #1;
      model_reset();
   endtask

   initial begin
      resetn = 1'b0; hold_all = 1'b0;
      p1_req = 1'b0; p2_req = 1'b0; vga_req = 1'b0;
      p1_addr = '0; p2_addr = '0; vga_addr = '0; p1_wdata = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      model_reset();

      // Preload RAM while in reset so every read has a known expected value.
      @(posedge clock); #1;
      for (int i = 0; i < 32; i++) begin
         load_en = 1'b1; load_addr = AW'(i); load_data = DW'($urandom);
         mem_m[i] = load_data;
         @(posedge clock); #1;
      end
      load_en = 1'b0;
      check_cleared("reset");
      release_reset();

      // Idle after reset
      repeat (10) step();
      check("idle_addr", 32'(ram_address), 32'd0);

      // p1 write 0x2E to addr 5, then p2 reads it back
      p1_req = 1'b1; p1_addr = AW'(5); p1_wdata = DW'(20'h2E);
      repeat (3) step();
      p2_req = 1'b1; p2_addr = AW'(5);
      repeat (RL + 4) step();
      check("p1_write_readback", 32'(rdata), 32'h2E);

      // All three requests held high from reset
      resetn = 1'b0; #1;
      release_reset();
      hold_all = 1'b1;
      p1_req = 1'b1; p2_req = 1'b1; vga_req = 1'b1;
      p1_addr = AW'(9); p1_wdata = DW'($urandom); p2_addr = AW'(9); vga_addr = AW'(20);
      repeat (24) step();
      hold_all = 1'b0;
      p1_req = 1'b0; p2_req = 1'b0; vga_req = 1'b0;
      repeat (RL + 4) step();

      // VGA read at the top address
      vga_req = 1'b1; vga_addr = AW'(31);
      repeat (RL + 4) step();

      // p2 request raised while busy with a VGA read
      vga_req = 1'b1; vga_addr = AW'($urandom);
      step();
      p2_req = 1'b1; p2_addr = AW'($urandom);
      repeat (RL + 8) step();

      // Reset during WAIT of a p2 read
      p2_req = 1'b1; p2_addr = AW'(5);
      step(); step();
      p2_req = 1'b0;
      resetn = 1'b0; #1;
      check_cleared("abort");
      @(posedge clock); @(posedge clock);
      release_reset();
      repeat (RL + 4) step();
      p1_req = 1'b1; p1_addr = AW'($urandom); p1_wdata = DW'($urandom);
      p2_req = 1'b1; p2_addr = AW'($urandom);
      vga_req = 1'b1; vga_addr = AW'($urandom);
      repeat (16) step();

      // Random traffic
      repeat (1500) begin
         rand_reqs();
         step();
      end
      p1_req = 1'b0; p2_req = 1'b0; vga_req = 1'b0;
      repeat (RL + 6) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
